// File: rtl/scr1_ialu_q_pkg.sv
// rtl/scr1_ialu_q_pkg.sv - shared types and constants for the IALU request queue
package scr1_ialu_q_pkg;

  // Default configuration; the queue entry and response layouts below are sized from these.
  localparam int SCR1_IALU_Q_XLEN  = 32;
  localparam int SCR1_IALU_Q_CMD_W = 32;
  localparam int SCR1_IALU_Q_TAG_W = 4;

  // Command value driven to the IALU when no request is queued.
  localparam logic [SCR1_IALU_Q_CMD_W-1:0] SCR1_IALU_Q_CMD_NONE = '0;

  // One queued request as held in the FIFO.
  typedef struct packed {
    logic [SCR1_IALU_Q_XLEN-1:0]  op1;
    logic [SCR1_IALU_Q_XLEN-1:0]  op2;
    logic [SCR1_IALU_Q_CMD_W-1:0] cmd;
    logic [SCR1_IALU_Q_TAG_W-1:0] tag;
  } type_scr1_ialu_q_entry_s;

  // Contents of the registered response slot.
  typedef struct packed {
    logic [SCR1_IALU_Q_XLEN-1:0]  main_res;
    logic                         cmp_res;
    logic [SCR1_IALU_Q_TAG_W-1:0] tag;
  } type_scr1_ialu_q_rsp_s;

endpackage

// File: rtl/scr1_ialu_req_fifo.sv
// rtl/scr1_ialu_req_fifo.sv - generic synchronous FIFO with flush and occupancy count
module scr1_ialu_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // Entry storage: data only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scr1_ialu_req_queue.sv
// rtl/scr1_ialu_req_queue.sv - request FIFO feeding the IALU plus registered response slot
module scr1_ialu_req_queue
  import scr1_ialu_q_pkg::*;
#(
  parameter int XLEN  = SCR1_IALU_Q_XLEN,
  parameter int CMD_W = SCR1_IALU_Q_CMD_W,
  parameter int DEPTH = 2,
  parameter int TAG_W = SCR1_IALU_Q_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     req_vd_i,
  output logic                     req_rdy_o,
  input  logic [XLEN-1:0]          req_op1_i,
  input  logic [XLEN-1:0]          req_op2_i,
  input  logic [CMD_W-1:0]         req_cmd_i,
  input  logic [TAG_W-1:0]         req_tag_i,
  output logic [XLEN-1:0]          exu2ialu_main_op1_o,
  output logic [XLEN-1:0]          exu2ialu_main_op2_o,
  output logic [CMD_W-1:0]         exu2ialu_cmd_o,
  input  logic [XLEN-1:0]          ialu2exu_main_res_i,
  input  logic                     ialu2exu_cmp_res_i,
  output logic                     rsp_vd_o,
  input  logic                     rsp_rdy_i,
  output logic [XLEN-1:0]          rsp_main_res_o,
  output logic                     rsp_cmp_res_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  type_scr1_ialu_q_entry_s wr_entry;
  type_scr1_ialu_q_entry_s head;
  type_scr1_ialu_q_rsp_s   rsp_q;
  logic                    rsp_vd_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    cap;

  assign wr_entry  = {req_op1_i, req_op2_i, req_cmd_i, req_tag_i};

  // Ready depends on FIFO occupancy only, keeping rsp_rdy_i/req_vd_i off this path.
  assign req_rdy_o = ~fifo_full;
  assign fifo_push = req_vd_i & ~fifo_full & ~flush_i;

  // Capture whenever there is a head and the response slot is free or being emptied this edge.
  assign cap       = ~fifo_empty & (~rsp_vd_q | rsp_rdy_i);
  assign fifo_pop  = cap & ~flush_i;

  scr1_ialu_req_fifo #(
    .WIDTH ($bits(type_scr1_ialu_q_entry_s)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (count_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Present the head to the IALU, or an idle NONE command when nothing is queued.
  always_comb begin
    exu2ialu_main_op1_o = '0;
    exu2ialu_main_op2_o = '0;
    exu2ialu_cmd_o      = SCR1_IALU_Q_CMD_NONE;
    if (!fifo_empty) begin
      exu2ialu_main_op1_o = head.op1;
      exu2ialu_main_op2_o = head.op2;
      exu2ialu_cmd_o      = head.cmd;
    end
  end

  // Response slot: flush drops it, capture loads it, a handshake with nothing behind it drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vd_q <= 1'b0;
      rsp_q    <= '0;
    end else if (flush_i) begin
      rsp_vd_q <= 1'b0;
    end else if (cap) begin
      rsp_vd_q       <= 1'b1;
      rsp_q.main_res <= ialu2exu_main_res_i;
      rsp_q.cmp_res  <= ialu2exu_cmp_res_i;
      rsp_q.tag      <= head.tag;
    end else if (rsp_vd_q && rsp_rdy_i) begin
      rsp_vd_q <= 1'b0;
    end
  end

  assign rsp_vd_o       = rsp_vd_q;
  assign rsp_main_res_o = rsp_q.main_res;
  assign rsp_cmp_res_o  = rsp_q.cmp_res;
  assign rsp_tag_o      = rsp_q.tag;

endmodule

// File: tb/tb_scr1_ialu_req_queue.sv
// tb/tb_scr1_ialu_req_queue.sv - directed self-checking bench for scr1_ialu_req_queue
module tb_scr1_ialu_req_queue;

  localparam logic [31:0] CMD_ADD = 32'd1;
  localparam logic [31:0] CMD_SUB = 32'd2;
  localparam logic [31:0] CMD_SLT = 32'd3;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_vd;
  logic        req_rdy;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [31:0] req_cmd;
  logic [3:0]  req_tag;
  logic [31:0] ialu_op1;
  logic [31:0] ialu_op2;
  logic [31:0] ialu_cmd;
  logic [31:0] ialu_res;
  logic        ialu_cmp;
  logic        rsp_vd;
  logic        rsp_rdy;
  logic [31:0] rsp_res;
  logic        rsp_cmp;
  logic [3:0]  rsp_tag;
  logic [1:0]  count;

  int total = 0;
  int bad   = 0;

  scr1_ialu_req_queue dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_i             (flush),
    .req_vd_i            (req_vd),
    .req_rdy_o           (req_rdy),
    .req_op1_i           (req_op1),
    .req_op2_i           (req_op2),
    .req_cmd_i           (req_cmd),
    .req_tag_i           (req_tag),
    .exu2ialu_main_op1_o (ialu_op1),
    .exu2ialu_main_op2_o (ialu_op2),
    .exu2ialu_cmd_o      (ialu_cmd),
    .ialu2exu_main_res_i (ialu_res),
    .ialu2exu_cmp_res_i  (ialu_cmp),
    .rsp_vd_o            (rsp_vd),
    .rsp_rdy_i           (rsp_rdy),
    .rsp_main_res_o      (rsp_res),
    .rsp_cmp_res_o       (rsp_cmp),
    .rsp_tag_o           (rsp_tag),
    .count_o             (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational IALU: ADD, SUB and signed SLT.
  always_comb begin
    ialu_res = '0;
    ialu_cmp = 1'b0;
    case (ialu_cmd)
      CMD_ADD: ialu_res = ialu_op1 + ialu_op2;
      CMD_SUB: ialu_res = ialu_op1 - ialu_op2;
      CMD_SLT: begin
        ialu_cmp = ($signed(ialu_op1) < $signed(ialu_op2));
        ialu_res = {31'b0, ialu_cmp};
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic vd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [3:0] t);
    req_vd  = vd;
    req_op1 = a;
    req_op2 = b;
    req_cmd = c;
    req_tag = t;
  endtask

  // Queue tags 1,2,3 (ADD 10t + t) with the response stalled: ends with count 2, slot holding tag 1.
  task automatic fill3();
    rsp_rdy = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      set_req(1'b1, 32'(t * 10), 32'(t), CMD_ADD, 4'(t));
      tick();
    end
    set_req(1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    int got;
    int bub;
    bit seen;

    rst_n   = 1'b0;
    flush   = 1'b0;
    rsp_rdy = 1'b1;
    set_req(1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rsp_vd", 64'(rsp_vd), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd1);
    chk("rst_cmd", 64'(ialu_cmd), 64'd0);

    // Single op: 5 + 3, tag 1.
    set_req(1'b1, 32'd5, 32'd3, CMD_ADD, 4'd1);
    tick();
    set_req(1'b0, '0, '0, '0, '0);
    chk("single_count_queued", 64'(count), 64'd1);
    chk("single_no_bypass", 64'(rsp_vd), 64'd0);
    tick();
    chk("single_vd", 64'(rsp_vd), 64'd1);
    chk("single_res", 64'(rsp_res), 64'd8);
    chk("single_tag", 64'(rsp_tag), 64'd1);
    chk("single_count", 64'(count), 64'd0);
    tick();
    chk("single_drain", 64'(rsp_vd), 64'd0);

    // Backpressure.
    fill3();
    chk("bp_count_full", 64'(count), 64'd2);
    chk("bp_req_rdy", 64'(req_rdy), 64'd0);
    chk("bp_tag_held", 64'(rsp_tag), 64'd1);
    set_req(1'b1, 32'd40, 32'd4, CMD_ADD, 4'd4);
    tick();
    tick();
    chk("bp_full_ignored", 64'(count), 64'd2);
    chk("bp_stable_vd", 64'(rsp_vd), 64'd1);
    chk("bp_stable_tag", 64'(rsp_tag), 64'd1);
    chk("bp_stable_res", 64'(rsp_res), 64'd11);
    set_req(1'b0, '0, '0, '0, '0);
    rsp_rdy = 1'b1;
    tick();
    chk("bp_tag2", 64'(rsp_tag), 64'd2);
    chk("bp_res2", 64'(rsp_res), 64'd22);
    chk("bp_vd2", 64'(rsp_vd), 64'd1);
    tick();
    chk("bp_tag3", 64'(rsp_tag), 64'd3);
    chk("bp_res3", 64'(rsp_res), 64'd33);
    chk("bp_count_empty", 64'(count), 64'd0);
    tick();
    chk("bp_drain", 64'(rsp_vd), 64'd0);

    // Streaming SUB (i+10) - i with tags 0..15.
    got  = 0;
    bub  = 0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) set_req(1'b1, 32'(c + 10), 32'(c), CMD_SUB, 4'(c));
      else        set_req(1'b0, '0, '0, '0, '0);
      tick();
      if (rsp_vd) begin
        chk("stream_tag", 64'(rsp_tag), 64'(got[3:0]));
        chk("stream_res", 64'(rsp_res), 64'd10);
        got++;
        seen = 1'b1;
      end else if (seen && got < 16) begin
        bub++;
      end
    end
    chk("stream_count", 64'(got), 64'd16);
    chk("stream_bubbles", 64'(bub), 64'd0);

    // Signed compare.
    set_req(1'b1, 32'hFFFF_FFFF, 32'd1, CMD_SLT, 4'd5);
    tick();
    set_req(1'b1, 32'd1, 32'hFFFF_FFFF, CMD_SLT, 4'd6);
    tick();
    set_req(1'b0, '0, '0, '0, '0);
    chk("slt_neg_vd", 64'(rsp_vd), 64'd1);
    chk("slt_neg_cmp", 64'(rsp_cmp), 64'd1);
    chk("slt_neg_tag", 64'(rsp_tag), 64'd5);
    tick();
    chk("slt_pos_cmp", 64'(rsp_cmp), 64'd0);
    chk("slt_pos_tag", 64'(rsp_tag), 64'd6);
    tick();

    // Flush with a request presented in the same cycle.
    fill3();
    chk("fl_pre_count", 64'(count), 64'd2);
    chk("fl_pre_vd", 64'(rsp_vd), 64'd1);
    flush = 1'b1;
    set_req(1'b1, 32'd9, 32'd9, CMD_ADD, 4'd9);
    tick();
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_vd", 64'(rsp_vd), 64'd0);
    chk("fl_req_rdy", 64'(req_rdy), 64'd1);
    tick();
    chk("fl_not_accepted", 64'(count), 64'd0);
    flush   = 1'b0;
    rsp_rdy = 1'b1;
    set_req(1'b1, 32'd2, 32'd2, CMD_ADD, 4'd7);
    tick();
    set_req(1'b0, '0, '0, '0, '0);
    tick();
    chk("fl_after_vd", 64'(rsp_vd), 64'd1);
    chk("fl_after_tag", 64'(rsp_tag), 64'd7);
    chk("fl_after_res", 64'(rsp_res), 64'd4);
    tick();

    // Asynchronous reset mid-stream.
    fill3();
    chk("ar_pre_count", 64'(count), 64'd2);
    chk("ar_pre_vd", 64'(rsp_vd), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_vd", 64'(rsp_vd), 64'd0);
    chk("ar_req_rdy", 64'(req_rdy), 64'd1);
    chk("ar_cmd", 64'(ialu_cmd), 64'd0);
    chk("ar_tag", 64'(rsp_tag), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_post_vd", 64'(rsp_vd), 64'd0);
    chk("ar_post_count", 64'(count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
